if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/lc3b_types.sv | 15 +
 rtl/if_id_queue.sv | 82 ++++++++
 tb/tb_if_id_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// ============================================================================
// lc3b_types : shared LC-3b datapath types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam lc3b_word LC3B_NOP = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
// if_id_queue : two-entry fetch-to-decode packet queue with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  lc3b_word   in_pc,
  input  lc3b_word   in_ir,
  output logic       in_ready,
  input  logic       out_ready,
  input  logic       flush,
  output logic       out_valid,
  output lc3b_word   out_pc,
  output lc3b_word   out_ir,
  output logic [1:0] count
);

  localparam logic [1:0] c_FULL = 2'(DEPTH);

  lc3b_word   r_pc [2];
  lc3b_word   r_ir [2];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;

  logic       w_push;
  logic       w_pop;

  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != 2'd0);
  assign count     = r_count;

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  // Outputs come only from stored entries; empty forces a NOP packet.
  assign out_pc = out_valid ? r_pc[r_head] : 16'h0000;
  assign out_ir = out_valid ? r_ir[r_head] : LC3B_NOP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_tail <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  // Entry storage carries no reset; contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_pc[r_tail] <= in_pc;
      r_ir[r_tail] <= in_ir;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
// tb_if_id_queue : directed self-checking bench for if_id_queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_id_queue;
  import lc3b_types::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  lc3b_word   in_pc;
  lc3b_word   in_ir;
  logic       in_ready;
  logic       out_ready;
  logic       flush;
  logic       out_valid;
  lc3b_word   out_pc;
  lc3b_word   out_ir;
  logic [1:0] count;

  int vecs;
  int errs;

  if_id_queue #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_ir     (in_ir),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_ir    (out_ir),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_pc     = 16'h0000;
    in_ir     = 16'h0000;
  endtask

  task automatic push(input lc3b_word pc, input lc3b_word ir);
    in_valid = 1'b1;
    in_pc    = pc;
    in_ir    = ir;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++;
    if (out_ir !== 16'h0000) begin errs++; $display("FAIL reset_out_ir got %h want 0000", out_ir); end
    vecs++;
    if (out_pc !== 16'h0000) begin errs++; $display("FAIL reset_out_pc got %h want 0000", out_pc); end
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++;
    if (count !== 2'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_single_push();
    push(16'h3000, 16'h1261);
    vecs++;
    if (out_valid !== 1'b1) begin errs++; $display("FAIL single_out_valid got %b want 1", out_valid); end
    vecs++;
    if (out_pc !== 16'h3000) begin errs++; $display("FAIL single_out_pc got %h want 3000", out_pc); end
    vecs++;
    if (out_ir !== 16'h1261) begin errs++; $display("FAIL single_out_ir got %h want 1261", out_ir); end
    vecs++;
    if (count !== 2'd1) begin errs++; $display("FAIL single_count got %0d want 1", count); end
    // Pop back to empty
    out_ready = 1'b1;
    step();
    idle();
    vecs++;
    if (count !== 2'd0) begin errs++; $display("FAIL single_pop_count got %0d want 0", count); end
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
    vecs++;
    if (out_ir !== 16'h0000) begin errs++; $display("FAIL single_pop_ir got %h want 0000", out_ir); end
  endtask

  task automatic test_fill();
    push(16'h3000, 16'hA000);
    push(16'h3002, 16'hA002);
    vecs++;
    if (count !== 2'd2) begin errs++; $display("FAIL fill_count got %0d want 2", count); end
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    push(16'h3004, 16'hA004);
    vecs++;
    if (count !== 2'd2) begin errs++; $display("FAIL fill_overflow_count got %0d want 2", count); end
    vecs++;
    if (out_pc !== 16'h3000) begin errs++; $display("FAIL fill_head0_pc got %h want 3000", out_pc); end
    vecs++;
    if (out_ir !== 16'hA000) begin errs++; $display("FAIL fill_head0_ir got %h want a000", out_ir); end
    out_ready = 1'b1;
    step();
    vecs++;
    if (out_pc !== 16'h3002) begin errs++; $display("FAIL fill_head1_pc got %h want 3002", out_pc); end
    vecs++;
    if (count !== 2'd1) begin errs++; $display("FAIL fill_pop1_count got %0d want 1", count); end
    step();
    idle();
    vecs++;
    if (count !== 2'd0) begin errs++; $display("FAIL fill_pop2_count got %0d want 0", count); end
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL fill_pop2_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    push(16'h3002, 16'hB002);
    in_valid  = 1'b1;
    in_pc     = 16'h3004;
    in_ir     = 16'hB004;
    out_ready = 1'b1;
    step();
    idle();
    vecs++;
    if (count !== 2'd1) begin errs++; $display("FAIL b2b_count got %0d want 1", count); end
    vecs++;
    if (out_pc !== 16'h3004) begin errs++; $display("FAIL b2b_out_pc got %h want 3004", out_pc); end
    vecs++;
    if (out_ir !== 16'hB004) begin errs++; $display("FAIL b2b_out_ir got %h want b004", out_ir); end
    out_ready = 1'b1;
    step();
    idle();
    vecs++;
    if (count !== 2'd0) begin errs++; $display("FAIL b2b_drain_count got %0d want 0", count); end
  endtask

  task automatic test_flush();
    push(16'h3100, 16'hC100);
    push(16'h3102, 16'hC102);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 16'h3104;
    in_ir     = 16'hC104;
    out_ready = 1'b1;
    step();
    idle();
    vecs++;
    if (count !== 2'd0) begin errs++; $display("FAIL flush_count got %0d want 0", count); end
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    vecs++;
    if (out_ir !== 16'h0000) begin errs++; $display("FAIL flush_out_ir got %h want 0000", out_ir); end
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    // Pointers restart at zero after flush
    push(16'h3200, 16'hC200);
    vecs++;
    if (out_pc !== 16'h3200) begin errs++; $display("FAIL flush_repush_pc got %h want 3200", out_pc); end
    out_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    push(16'h3300, 16'hD300);
    push(16'h3302, 16'hD302);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vecs++;
    if (count !== 2'd0) begin errs++; $display("FAIL rstmid_count got %0d want 0", count); end
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    push(16'h4000, 16'hD400);
    vecs++;
    if (out_pc !== 16'h4000) begin errs++; $display("FAIL rstmid_push_pc got %h want 4000", out_pc); end
    vecs++;
    if (out_ir !== 16'hD400) begin errs++; $display("FAIL rstmid_push_ir got %h want d400", out_ir); end
    vecs++;
    if (count !== 2'd1) begin errs++; $display("FAIL rstmid_push_count got %0d want 1", count); end
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single_push();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
